fifo_burst_reader: RTL and testbench



---
 rtl/fifo_burst_reader_if.sv | 31 +++
 rtl/fifo_burst_reader.sv | 93 +++++++++
 tb/tb_fifo_burst_reader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus output beat stream of the burst reader, grouped for port connection.
// master = the reader itself, slave = the FIFO/downstream environment.
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_almost_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  burst_busy;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data, fifo_empty, fifo_almost_empty,
    output m_valid,
    input  m_ready,
    output m_data, m_last, burst_busy
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data, fifo_empty, fifo_almost_empty,
    input  m_valid,
    output m_ready,
    input  m_data, m_last, burst_busy
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains the async FIFO read port through a 2-entry skid buffer into a valid/ready stream,
// flagging every BURST_LEN-th beat with m_last. Optional first-fetch gate: FIFO_BURST_READER_AE_GATE_EN.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic               rd_clk,
  input  logic               rd_rstn,
  fifo_burst_reader_if.master bus
);

  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [1:0]            cnt;
  logic                  inflight;
  logic                  rptr;
  logic                  wptr;
  logic [DATA_WIDTH-1:0] mem [2];
  logic [BW-1:0]         bcnt;
  logic                  deq;
  logic [2:0]            occ;
  logic                  room;
  logic                  gate_ok;
  logic                  pop;

  assign bus.m_valid    = (cnt != 2'd0);
  assign bus.m_data     = mem[rptr];
  assign bus.m_last     = bus.m_valid & (bcnt == LAST_BEAT);
  assign bus.burst_busy = (state == BURST);

  // Words already held plus the one in flight must leave a free slot after this cycle's dequeue.
  assign deq  = bus.m_valid & bus.m_ready;
  assign occ  = {1'b0, cnt} + {2'b00, inflight};
  assign room = (occ < (3'd2 + {2'b00, deq}));

`ifdef FIFO_BURST_READER_AE_GATE_EN
  logic [BW-1:0] fcnt;

  // The first fetch of a burst waits until the FIFO is past almost-empty.
  assign gate_ok = (fcnt != '0) | ~bus.fifo_almost_empty;

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      fcnt <= '0;
    end else if (pop) begin
      fcnt <= (fcnt == LAST_BEAT) ? '0 : BW'(fcnt + 1'b1);
    end
  end
`else
  logic unused_almost_empty;

  assign unused_almost_empty = bus.fifo_almost_empty;
  assign gate_ok             = 1'b1;
`endif

  assign pop            = rd_rstn & ~bus.fifo_empty & room & gate_ok;
  assign bus.fifo_rd_en = pop;

  // Skid buffer, read-latency tracking, beat counter and burst FSM.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      inflight <= 1'b0;
      rptr     <= 1'b0;
      wptr     <= 1'b0;
      bcnt     <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= pop;
      cnt      <= cnt + {1'b0, inflight} - {1'b0, deq};
      if (inflight) begin
        mem[wptr] <= bus.fifo_rd_data;
        wptr      <= ~wptr;
      end
      if (deq) begin
        rptr <= ~rptr;
        bcnt <= (bcnt == LAST_BEAT) ? '0 : BW'(bcnt + 1'b1);
        case (state)
          IDLE:    if (BURST_LEN > 1) state <= BURST;
          BURST:   if (bus.m_last) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader (BURST_LEN=4) with a behavioural FIFO model on the read port.
module tb_fifo_burst_reader;

  logic        clk;
  logic        rst_n;
  int          n_checks;
  int          n_fail;
  bit   [11:0] wr_ptr;
  bit   [11:0] rd_ptr;
  logic [31:0] fmem [4096];
  logic [31:0] exp_q [$];
  int          beat;
  logic [31:0] next_val;
  int          pops;
  int          pushed;
  logic [31:0] exp_pops;
  logic [31:0] exp_rem;

  fifo_burst_reader_if #(.DATA_WIDTH(32)) bus ();

  fifo_burst_reader #(.DATA_WIDTH(32), .BURST_LEN(4)) dut (
    .rd_clk  (clk),
    .rd_rstn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency, flushed by reset.
  assign bus.fifo_empty        = (wr_ptr == rd_ptr);
  assign bus.fifo_almost_empty = (12'(wr_ptr - rd_ptr) <= 12'd4);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= fmem[rd_ptr];
      rd_ptr           <= rd_ptr + 12'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word();
    fmem[wr_ptr] = next_val;
    exp_q.push_back(next_val);
    wr_ptr   = wr_ptr + 12'd1;
    next_val = next_val + 32'd1;
  endtask

  // One clock: drive ready and pushes after the edge, then score any beat that will be accepted.
  task automatic run_cycle(input logic rdy, input int npush);
    logic [31:0] e;
    @(posedge clk);
    #1;
    bus.m_ready = rdy;
    for (int i = 0; i < npush; i++) push_word();
    #1;
    check("rd_en_while_empty", 32'(bus.fifo_rd_en & bus.fifo_empty), 32'd0);
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(bus.m_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", bus.m_data, e);
        check("beat_last", 32'(bus.m_last), 32'(beat == 3));
        beat = (beat + 1) % 4;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    beat        = 0;
    next_val    = 32'd0;
    rst_n       = 1'b0;
    bus.m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_data", bus.m_data, 32'd0);
    check("rst_last", 32'(bus.m_last), 32'd0);
    check("rst_busy", 32'(bus.burst_busy), 32'd0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    rst_n = 1'b1;

    // Basic stream: 8 words, ready high, two aligned bursts
    next_val = 32'd0;
    for (int c = 0; c < 12; c++) begin
      run_cycle(1'b1, (c == 0) ? 8 : 0);
      check("t1_rd_en", 32'(bus.fifo_rd_en), 32'(c < 8));
      check("t1_valid", 32'(bus.m_valid), 32'(c >= 2 && c <= 9));
      check("t1_busy", 32'(bus.burst_busy), 32'((c >= 3 && c <= 5) || (c >= 7 && c <= 9)));
    end
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: ready low for 10 cycles with 12 words available
    next_val = 32'h100;
    pops     = 0;
    for (int c = 0; c < 10; c++) begin
      run_cycle(1'b0, (c == 0) ? 12 : 0);
      if (bus.fifo_rd_en) pops++;
      if (c >= 2) begin
        check("t2_valid", 32'(bus.m_valid), 32'd1);
        check("t2_data_hold", bus.m_data, 32'h100);
        check("t2_last", 32'(bus.m_last), 32'd0);
      end
    end
    check("t2_pops", 32'(pops), 32'd2);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) run_cycle(1'b1, 0);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Underflow mid-burst: 2 words, gap, 2 more
    next_val = 32'h200;
    for (int c = 0; c < 8; c++) begin
      run_cycle(1'b1, (c == 0) ? 2 : 0);
      if (c >= 4) begin
        check("t3_gap_valid", 32'(bus.m_valid), 32'd0);
        check("t3_gap_busy", 32'(bus.burst_busy), 32'd1);
      end
    end
    run_cycle(1'b1, 2);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) run_cycle(1'b1, 0);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    run_cycle(1'b1, 0);
    check("t3_closed", 32'(bus.burst_busy), 32'd0);

    // Random ready and random FIFO fill, 1000 words
    next_val = 32'h1000;
    pushed   = 0;
    for (int k = 0; k < 6000; k++) begin
      int np;
      np = (pushed < 1000 && $urandom_range(0, 2) != 0) ? 1 : 0;
      pushed += np;
      run_cycle(1'($urandom_range(0, 1)), np);
      if (pushed == 1000 && exp_q.size() == 0) break;
    end
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    run_cycle(1'b1, 0);

    // Async reset after two beats of a burst
    next_val = 32'h50;
    run_cycle(1'b1, 4);
    for (int c = 1; c < 4; c++) run_cycle(1'b1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(bus.m_valid), 32'd0);
    check("t5_data", bus.m_data, 32'd0);
    check("t5_last", 32'(bus.m_last), 32'd0);
    check("t5_busy", 32'(bus.burst_busy), 32'd0);
    check("t5_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    exp_q.delete();
    beat = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    next_val = 32'hA0;
    run_cycle(1'b1, 4);
    run_cycle(1'b1, 0);
    run_cycle(1'b1, 0);
    check("t5_new_valid", 32'(bus.m_valid), 32'd1);
    check("t5_new_busy", 32'(bus.burst_busy), 32'd0);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) run_cycle(1'b1, 0);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    run_cycle(1'b1, 0);

    // Almost-empty gate on the first fetch of a burst
`ifdef FIFO_BURST_READER_AE_GATE_EN
    exp_pops = 32'd0;
    exp_rem  = 32'd2;
`else
    exp_pops = 32'd2;
    exp_rem  = 32'd0;
`endif
    next_val = 32'h300;
    pops     = 0;
    for (int c = 0; c < 3; c++) begin
      run_cycle(1'b0, (c == 0) ? 3 : 0);
      if (bus.fifo_rd_en) pops++;
    end
    check("t6_pops_3words", 32'(pops), exp_pops);
    run_cycle(1'b0, 3);
    check("t6_rd_en_6words", 32'(bus.fifo_rd_en), 32'd1 - exp_pops[1:0] / 2);
    for (int k = 0; k < 20 && exp_q.size() > int'(exp_rem); k++) run_cycle(1'b1, 0);
    check("t6_remaining", 32'(exp_q.size()), exp_rem);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
